// File: rtl/cone_state_tracker.sv
// cone_state_tracker
// Registered tracker for NCH single-bit state cones. Each channel toggles
// only under a unanimous vote group, or loads an alternate value. Repeated
// disagreement drives the channel into a lock-out state, which is reported
// through a valid/ready event port, lowest channel first.
// Optional feature: define CTRK_PARITY_EN to build a registered parity of q.
module cone_state_tracker #(
    parameter  int NCH     = 4,
    parameter  int GRP_W   = 3,
    parameter  int CNT_W   = 4,
    parameter  int LOCK_TH = 3,
    localparam int EW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               CK,
    input  logic               RST,
    input  logic [NCH*GRP_W-1:0] grp,
    input  logic [NCH-1:0]     sel,
    input  logic [NCH-1:0]     tog,
    input  logic [NCH-1:0]     alt,
    input  logic [NCH-1:0]     clr,
    output logic [NCH-1:0]     q,
    output logic [NCH-1:0]     lock,
    output logic               evt_valid,
    output logic [EW-1:0]      evt_ch,
    input  logic               evt_ready,
    output logic               q_par
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_LOCK    = 2'd2
    } state_t;

    state_t           r_state [NCH];
    logic [CNT_W-1:0] r_cnt   [NCH];
    logic [NCH-1:0]   r_q;
    logic [NCH-1:0]   r_pend;

    logic [NCH-1:0]   w_agree;
    logic [NCH-1:0]   w_lock_enter;
    logic [NCH-1:0]   w_q_nxt;
    logic [NCH-1:0]   w_clr_mask;
    logic [EW-1:0]    w_evt_ch;

    // Vote evaluation, lock-entry detection and next state-bit value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_agree      = '0;
        w_lock_enter = '0;
        w_q_nxt      = r_q;
        for (int i = 0; i < NCH; i++) begin
            w_agree[i] = (&grp[i*GRP_W +: GRP_W]) | ~(|grp[i*GRP_W +: GRP_W]);
            if (!w_agree[i]) begin
                if (r_state[i] == ST_RUN && LOCK_TH == 1)
                    w_lock_enter[i] = 1'b1;
                else if (r_state[i] == ST_SUSPECT &&
                         ((CNT_W+1)'(r_cnt[i]) + 1'b1) >= (CNT_W+1)'(LOCK_TH))
                    w_lock_enter[i] = 1'b1;
            end
            if (r_state[i] == ST_LOCK || w_lock_enter[i])
                w_q_nxt[i] = 1'b0;
            else if (!sel[i])
                w_q_nxt[i] = alt[i];
            else if (w_agree[i])
                w_q_nxt[i] = r_q[i] ^ tog[i];
        end
    end

    // Per-channel RUN/SUSPECT/LOCK machine with its disagreement counter.
    always_ff @(posedge CK) begin
        // NOTE: state registers use non-blocking assignments so all channels see pre-edge values.
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= ST_RUN;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (r_state[i])
                    ST_RUN: begin
                        if (w_lock_enter[i]) begin
                            r_state[i] <= ST_LOCK;
                            r_cnt[i]   <= '0;
                        end else if (!w_agree[i]) begin
                            r_state[i] <= ST_SUSPECT;
                            r_cnt[i]   <= CNT_W'(1);
                        end
                    end
                    ST_SUSPECT: begin
                        if (w_agree[i]) begin
                            r_state[i] <= ST_RUN;
                            r_cnt[i]   <= '0;
                        end else if (w_lock_enter[i]) begin
                            r_state[i] <= ST_LOCK;
                            r_cnt[i]   <= '0;
                        end else begin
                            r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    ST_LOCK: begin
                        r_cnt[i] <= '0;
                        if (clr[i])
                            r_state[i] <= ST_RUN;
                    end
                    default: begin
                        r_state[i] <= ST_RUN;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Channel state bits.
    always_ff @(posedge CK) begin
        if (RST) r_q <= '0;
        else     r_q <= w_q_nxt;
    end

    // Lowest pending channel is the one reported; handshake clears only that bit.
    always_comb begin
        w_evt_ch   = '0;
        w_clr_mask = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_pend[i]) w_evt_ch = EW'(i);
        end
        if (|r_pend && evt_ready)
            w_clr_mask[w_evt_ch] = 1'b1;
    end

    // Pending lock events; a new lock on the same edge as its ack wins.
    always_ff @(posedge CK) begin
        if (RST) r_pend <= '0;
        else     r_pend <= (r_pend & ~w_clr_mask) | w_lock_enter;
    end

`ifdef CTRK_PARITY_EN
    logic r_q_par;

    // Parity register tracks q on the same edge.
    always_ff @(posedge CK) begin
        if (RST) r_q_par <= 1'b0;
        else     r_q_par <= ^w_q_nxt;
    end

    assign q_par = r_q_par;
`else
    assign q_par = 1'b0;
`endif

    // Outputs decoded only from registers.
    always_comb begin
        lock = '0;
        for (int i = 0; i < NCH; i++)
            lock[i] = (r_state[i] == ST_LOCK);
    end

    assign q         = r_q;
    assign evt_valid = |r_pend;
    assign evt_ch    = w_evt_ch;

endmodule
